// File: rtl/mem_burst_master.sv
// mem_burst_master: one-request-at-a-time burst initiator for main memory.
// Optional range check on requests: define MEM_BURST_MASTER_ADDR_CHECK_EN.
module mem_burst_master #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000,
    parameter int unsigned MEM_SIZE = 1048578
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_wr,
    input  logic [DATA_SIZE-1:0]    wdata,
    output logic                    wdata_pop,
    output logic [DATA_SIZE-1:0]    rdata,
    output logic                    rdata_valid,
    output logic                    rdata_last,
    output logic                    done,
    output logic                    err,
    output logic                    mem_enable,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [1:0]              mem_acc_size,
    output logic                    mem_wren,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    input  logic [DATA_SIZE-1:0]    mem_rdata,
    input  logic                    mem_busy
);

    typedef enum logic [1:0] {IDLE, BEAT, RTAIL, FIN} state_t;

    state_t                  state;
    logic [3:0]              k;
    logic [3:0]              k_last;
    logic [3:0]              req_last;
    logic                    wr_q;
    logic                    accept;
    logic                    reject;
    logic [ADDRESS_SIZE-1:0] base;
    logic                    unused_in;

    assign base      = {req_addr[ADDRESS_SIZE-1:2], 2'b00};
    assign accept    = req_valid & req_ready;
    assign unused_in = ^{mem_busy, req_addr[1:0]};

    always_comb begin
        unique case (req_size)
            2'd0:    req_last = 4'd0;
            2'd1:    req_last = 4'd3;
            2'd2:    req_last = 4'd7;
            default: req_last = 4'd15;
        endcase
    end

`ifdef MEM_BURST_MASTER_ADDR_CHECK_EN
    localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE+1)'(MEM_SIZE);

    logic [6:0]            nbytes;
    logic [ADDRESS_SIZE:0] span;

    assign nbytes = {5'(req_last) + 5'd1, 2'b00};
    assign span   = {1'b0, base - START_ADDRESS} + (ADDRESS_SIZE+1)'(nbytes);
    assign reject = (base < START_ADDRESS) || (span > MEM_LIMIT);
`else
    logic unused_cfg;

    assign unused_cfg = ^{START_ADDRESS, MEM_SIZE};
    assign reject     = 1'b0;
`endif

    // Read data and write data pass straight through in their beat cycles.
    assign rdata     = rdata_valid ? mem_rdata : '0;
    assign mem_wdata = wdata_pop ? wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            k_last       <= '0;
            wr_q         <= 1'b0;
            req_ready    <= 1'b1;
            mem_enable   <= 1'b0;
            mem_addr     <= '0;
            mem_acc_size <= '0;
            mem_wren     <= 1'b0;
            wdata_pop    <= 1'b0;
            rdata_valid  <= 1'b0;
            rdata_last   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            mem_enable <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && reject) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        mem_addr     <= base;
                        mem_acc_size <= req_size;
                        mem_wren     <= req_wr;
                        wdata_pop    <= req_wr;
                        mem_enable   <= 1'b1;
                        wr_q         <= req_wr;
                        k            <= '0;
                        k_last       <= req_last;
                        req_ready    <= 1'b0;
                        state        <= BEAT;
                    end
                end
                BEAT: begin
                    rdata_valid <= !wr_q;
                    if (k == k_last) begin
                        wdata_pop <= 1'b0;
                        if (wr_q) begin
                            mem_wren <= 1'b0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            rdata_last <= 1'b1;
                            state      <= RTAIL;
                        end
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                RTAIL: begin
                    rdata_valid <= 1'b0;
                    rdata_last  <= 1'b0;
                    done        <= 1'b1;
                    state       <= FIN;
                end
                FIN: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: randomized and directed bursts against a memory
// model; expectations come from a reference memory and latency rules.
`timescale 1ns/1ps
module tb_mem_burst_master;

    localparam logic [31:0] START = 32'h80020000;
    localparam int unsigned MSIZE = 1048578;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] wdata, rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        wdata_pop, rdata_valid, rdata_last, done, err;
    logic        mem_enable, mem_wren;
    logic [1:0]  mem_acc_size;
    logic        mem_busy = 1'b0;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_burst_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_wr(req_wr),
        .wdata(wdata), .wdata_pop(wdata_pop),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .done(done), .err(err),
        .mem_enable(mem_enable), .mem_addr(mem_addr),
        .mem_acc_size(mem_acc_size), .mem_wren(mem_wren),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    // Client write FIFO, first-word-fall-through.
    logic [31:0] wbuf [64];
    logic [5:0]  rp = '0;
    logic [5:0]  wp = '0;
    assign wdata = wbuf[rp];
    always @(posedge clk) if (wdata_pop) rp <= rp + 6'd1;

    function automatic int nwords(input logic [1:0] s);
        case (s)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory device: burst starts on enable, auto-increments by 4.
    logic [31:0] dmem [logic [31:0]];
    int          m_left = 0;
    int          m_k = 0;
    logic [31:0] m_base, m_a;
    logic        m_wr;
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
        end else begin
            if (mem_enable) begin
                m_base = mem_addr;
                m_wr   = mem_wren;
                m_k    = 0;
                m_left = nwords(mem_acc_size);
            end
            if (m_left > 0) begin
                m_a = m_base + 32'(4 * m_k);
                if (m_wr) dmem[m_a] = mem_wdata;
                else mem_rdata <= dmem.exists(m_a) ? dmem[m_a] : init_word(m_a);
                m_k++;
                m_left--;
            end
        end
    end

    // Reference memory contents as seen by the client.
    logic [31:0] ref_mem [logic [31:0]];
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    typedef struct { int c; logic [31:0] d; logic l; } beat_t;
    beat_t       rv_q[$];
    beat_t       pop_q[$];
    beat_t       mb;
    int          en_q[$], done_q[$], err_q[$], hs_q[$], rise_q[$];
    logic [31:0] addr_log [int];
    logic [1:0]  acc_log [int];
    logic        wren_log [int];
    logic        ready_prev = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) hs_q.push_back(cyc);
            if (mem_enable) en_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (err) err_q.push_back(cyc);
            if (wdata_pop) begin
                mb.c = cyc; mb.d = mem_wdata; mb.l = 1'b0;
                pop_q.push_back(mb);
            end
            if (rdata_valid || rdata_last) begin
                mb.c = cyc; mb.d = rdata; mb.l = rdata_last;
                rv_q.push_back(mb);
            end
            if (req_ready && !ready_prev) rise_q.push_back(cyc);
            addr_log[cyc] = mem_addr;
            acc_log[cyc]  = mem_acc_size;
            wren_log[cyc] = mem_wren;
        end
        ready_prev = req_ready;
    end

    task automatic clear_logs();
        rv_q.delete(); pop_q.delete(); en_q.delete(); done_q.delete();
        err_q.delete(); hs_q.delete(); rise_q.delete();
        addr_log.delete(); acc_log.delete(); wren_log.delete();
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d);
        wbuf[wp] = d;
        wp = wp + 6'd1;
        ref_mem[a] = d;
    endtask

    task automatic do_burst(input logic [31:0] a, input logic [1:0] s,
                            input logic w, input bit hold, output int t);
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a; req_size = s; req_wr = w;
        t = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            total++;
            $display("FAIL handshake: req_ready=0 after 40 cycles, want 1");
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
        else passed++;
        total++;
        if ({mem_enable, mem_addr, mem_acc_size, mem_wren, mem_wdata, wdata_pop,
             rdata, rdata_valid, rdata_last, done, err} !== '0)
            $display("FAIL reset_outs: got nonzero outputs, want all 0");
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL post_reset: got ready=%b done=%b want 1/0", req_ready, done);
        else passed++;
    endtask

    task automatic test_single_write();
        int t;
        clear_logs();
        push_w(START, 32'hDEADBEEF);
        do_burst(START, 2'd0, 1'b1, 1'b0, t);
        repeat (4) @(posedge clk); #1;
        total++;
        if (en_q.size() != 1 || en_q[0] != t + 1)
            $display("FAIL w1_enable: got %0d pulses want 1 at %0d", en_q.size(), t + 1);
        else passed++;
        total++;
        if (wren_log[t+1] !== 1'b1 || addr_log[t+1] !== START)
            $display("FAIL w1_pins: got wren=%b addr=%h want 1/%h", wren_log[t+1], addr_log[t+1], START);
        else passed++;
        total++;
        if (pop_q.size() != 1 || pop_q[0].c != t + 1 || pop_q[0].d !== 32'hDEADBEEF)
            $display("FAIL w1_pop: got %0d pops want 1 of DEADBEEF at %0d", pop_q.size(), t + 1);
        else passed++;
        total++;
        if (done_q.size() != 1 || done_q[0] != t + 2)
            $display("FAIL w1_done: got %0d pulses want 1 at %0d", done_q.size(), t + 2);
        else passed++;
        clear_logs();
        do_burst(START, 2'd0, 1'b0, 1'b0, t);
        repeat (5) @(posedge clk); #1;
        total++;
        if (rv_q.size() != 1 || rv_q[0].c != t + 2 || rv_q[0].d !== 32'hDEADBEEF || rv_q[0].l !== 1'b1)
            $display("FAIL r1_data: got %0d beats want 1 beat DEADBEEF last at %0d", rv_q.size(), t + 2);
        else passed++;
        total++;
        if (done_q.size() != 1 || done_q[0] != t + 3)
            $display("FAIL r1_done: got %0d pulses want 1 at %0d", done_q.size(), t + 3);
        else passed++;
    endtask

    task automatic test_quad();
        int t, bad;
        logic [31:0] a;
        a = 32'h80020010;
        clear_logs();
        for (int i = 0; i < 4; i++) push_w(a + 32'(4 * i), 32'(i + 1));
        do_burst(a, 2'd1, 1'b1, 1'b0, t);
        repeat (6) @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (pop_q.size() != 4) bad++;
            else if (pop_q[i].c != t + 1 + i || pop_q[i].d !== 32'(i + 1)) bad++;
            if (addr_log[t+1+i] !== a) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL w4_beats: got %0d bad beats want 0", bad);
        else passed++;
        total++;
        if (done_q.size() != 1 || done_q[0] != t + 5)
            $display("FAIL w4_done: got %0d pulses want 1 at %0d", done_q.size(), t + 5);
        else passed++;
        clear_logs();
        do_burst(a, 2'd1, 1'b0, 1'b0, t);
        repeat (7) @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (rv_q.size() != 4) bad++;
            else if (rv_q[i].c != t + 2 + i || rv_q[i].d !== 32'(i + 1) || rv_q[i].l !== (i == 3)) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL r4_data: got %0d bad beats of %0d want 0", bad, rv_q.size());
        else passed++;
        total++;
        if (done_q.size() != 1 || done_q[0] != t + 6)
            $display("FAIL r4_done: got %0d pulses want 1 at %0d", done_q.size(), t + 6);
        else passed++;
    endtask

    task automatic test_hold();
        int t, bad, cnt;
        logic [31:0] a;
        a = START + 32'h400;
        clear_logs();
        do_burst(a, 2'd3, 1'b0, 1'b1, t);
        for (int n = 0; n < 40 && hs_q.size() < 2; n++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (hs_q.size() < 2 || hs_q[1] != t + 19)
            $display("FAIL hold_accept: got %0d handshakes want second at %0d", hs_q.size(), t + 19);
        else passed++;
        bad = 0;
        cnt = 0;
        foreach (rv_q[i]) begin
            if (rv_q[i].c <= t + 19) begin
                if (rv_q[i].c != t + 2 + cnt || rv_q[i].d !== exp_word(a + 32'(4 * cnt))
                    || rv_q[i].l !== (cnt == 15)) bad++;
                cnt++;
            end
        end
        total++;
        if (cnt != 16 || bad != 0)
            $display("FAIL hold_data: got %0d beats %0d bad want 16 beats 0 bad", cnt, bad);
        else passed++;
        repeat (22) @(posedge clk); #1;
        total++;
        if (done_q.size() != 2 || rv_q.size() != 32)
            $display("FAIL hold_second: got %0d done %0d beats want 2/32", done_q.size(), rv_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int t;
        clear_logs();
        do_burst(START + 32'h800, 2'd3, 1'b0, 1'b0, t);
        repeat (5) @(posedge clk); #2;
        total++;
        if (rdata_valid !== 1'b1) $display("FAIL mid_pre: got rdata_valid=%b want 1", rdata_valid);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (rdata_valid !== 1'b0 || mem_enable !== 1'b0 || mem_addr !== '0)
            $display("FAIL mid_async: got valid=%b en=%b addr=%h want 0/0/0", rdata_valid, mem_enable, mem_addr);
        else passed++;
        total++;
        if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", req_ready);
        else passed++;
        clear_logs();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk); #1;
        total++;
        if (done_q.size() != 0 || rv_q.size() != 0 || req_ready !== 1'b1)
            $display("FAIL mid_after: got done=%0d beats=%0d ready=%b want 0/0/1", done_q.size(), rv_q.size(), req_ready);
        else passed++;
    endtask

    task automatic test_addr_check();
        logic [31:0] addrs [2];
        int t, bad;
        addrs[0] = 32'h80010000;
        addrs[1] = START + MSIZE - 8;
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            do_burst(addrs[j], 2'd1, 1'b0, 1'b0, t);
            repeat (7) @(posedge clk); #1;
`ifdef MEM_BURST_MASTER_ADDR_CHECK_EN
            total++;
            if (err_q.size() != 1 || err_q[0] != t + 1)
                $display("FAIL chk_err%0d: got %0d pulses want 1 at %0d", j, err_q.size(), t + 1);
            else passed++;
            total++;
            if (en_q.size() != 0 || done_q.size() != 0 || rv_q.size() != 0)
                $display("FAIL chk_quiet%0d: got en=%0d done=%0d want 0/0", j, en_q.size(), done_q.size());
            else passed++;
`else
            bad = 0;
            foreach (rv_q[i])
                if (rv_q[i].d !== exp_word({addrs[j][31:2], 2'b00} + 32'(4 * i))) bad++;
            total++;
            if (err_q.size() != 0 || en_q.size() != 1 || rv_q.size() != 4 || bad != 0)
                $display("FAIL chk_pass%0d: got err=%0d en=%0d beats=%0d bad=%0d want 0/1/4/0", j, err_q.size(), en_q.size(), rv_q.size(), bad);
            else passed++;
            total++;
            if (done_q.size() != 1 || done_q[0] != t + 6)
                $display("FAIL chk_done%0d: got %0d pulses want 1 at %0d", j, done_q.size(), t + 6);
            else passed++;
`endif
        end
    endtask

    task automatic test_random();
        int t, n, bad;
        logic [1:0] s;
        logic w;
        logic [31:0] a, base;
        for (int it = 0; it < 20; it++) begin
            s = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = START + 32'(4 * $urandom_range(0, 3000)) + 32'($urandom_range(0, 3));
            base = {a[31:2], 2'b00};
            n = nwords(s);
            clear_logs();
            if (w) for (int i = 0; i < n; i++) push_w(base + 32'(4 * i), $urandom);
            do_burst(a, s, w, 1'b0, t);
            repeat (n + 4) @(posedge clk); #1;
            total++;
            if (en_q.size() != 1 || en_q[0] != t + 1)
                $display("FAIL rnd%0d_enable: got %0d pulses want 1 at %0d", it, en_q.size(), t + 1);
            else passed++;
            total++;
            if (done_q.size() != 1 || done_q[0] != t + n + (w ? 1 : 2))
                $display("FAIL rnd%0d_done: got %0d pulses want 1 at %0d", it, done_q.size(), t + n + (w ? 1 : 2));
            else passed++;
            total++;
            if (rise_q.size() != 1 || rise_q[0] != t + n + (w ? 2 : 3))
                $display("FAIL rnd%0d_ready: got %0d rises want 1 at %0d", it, rise_q.size(), t + n + (w ? 2 : 3));
            else passed++;
            bad = 0;
            for (int i = 0; i < n; i++)
                if (addr_log[t+1+i] !== base || acc_log[t+1+i] !== s || wren_log[t+1+i] !== w) bad++;
            total++;
            if (bad != 0) $display("FAIL rnd%0d_pins: got %0d bad beats want 0", it, bad);
            else passed++;
            bad = 0;
            for (int i = 0; i < n; i++) begin
                if (w) begin
                    if (pop_q.size() != n || rv_q.size() != 0) bad++;
                    else if (pop_q[i].c != t + 1 + i || pop_q[i].d !== exp_word(base + 32'(4 * i))) bad++;
                end else begin
                    if (rv_q.size() != n || pop_q.size() != 0) bad++;
                    else if (rv_q[i].c != t + 2 + i || rv_q[i].d !== exp_word(base + 32'(4 * i))
                             || rv_q[i].l !== (i == n - 1)) bad++;
                end
            end
            total++;
            if (bad != 0) $display("FAIL rnd%0d_data: got %0d bad beats want 0", it, bad);
            else passed++;
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wr    = 1'b0;
        test_reset();
        test_single_write();
        test_quad();
        test_hold();
        test_reset_mid();
        test_addr_check();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the main-memory burst interface; sits between the CPU-side fetch/load-store logic and main memory.
- Accepts one request at a time: base address, access size, read or write.
- Drives the memory's enable, address, access-size and write-enable pins. Supplies write beats from a client FIFO and returns read beats as a valid/last stream.
- Counts beats internally; completion never depends on memory busy.

Parameters:
- ADDRESS_SIZE, 32, address width.
- DATA_SIZE, 32, data width; one word = 4 bytes.
- START_ADDRESS, 32'h80020000, lowest legal memory address.
- MEM_SIZE, 1048578, memory size in bytes (used only by the optional check).

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, request accepted when req_valid & req_ready.
- req_addr  in  ADDRESS_SIZE  byte base address; bits [1:0] ignored (forced 0).
- req_size  in  2  0=1 word, 1=4, 2=8, 3=16 words.
- req_wr  in  1  1=write burst, 0=read burst.
- wdata  in  DATA_SIZE  head of client write FIFO (first-word-fall-through).
- wdata_pop  out  1  consume wdata this cycle.
- rdata  out  DATA_SIZE  read beat.
- rdata_valid  out  1  rdata valid this cycle.
- rdata_last  out  1  final read beat of burst.
- done  out  1  one-cycle pulse, burst complete.
- err  out  1  one-cycle pulse, request rejected (optional feature only; else 0).
- mem_enable  out  1  to memory enable.
- mem_addr  out  ADDRESS_SIZE  to memory addr.
- mem_acc_size  out  2  to memory acc_size.
- mem_wren  out  1  to memory wren.
- mem_wdata  out  DATA_SIZE  to memory d_in.
- mem_rdata  in  DATA_SIZE  from memory d_out.
- mem_busy  in  1  from memory busy; ignored by the state machine.

Behaviour:
- Reset values:
  - req_ready=1.
  - All other outputs 0, including mem_addr, mem_acc_size and mem_wdata.
  - State IDLE, beat counter 0.
- Reset mid-burst: outputs go to reset values immediately (asynchronous); the burst is abandoned with no done pulse.
- States: IDLE, BEAT, RTAIL, FIN.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr/size/wr, compute N = {1,4,8,16}, clear beat counter k, go to BEAT.
- BEAT, one cycle per beat, k = 0..N-1:
  - mem_addr = latched base, held constant for the whole burst (memory increments internally by 4 per beat).
  - mem_acc_size and mem_wren held for the whole burst.
  - mem_enable=1 only on k=0, 0 otherwise.
  - Write: mem_wdata=wdata and wdata_pop=1 every BEAT cycle. The client guarantees all N words are in its FIFO before asserting req_valid.
  - On k=N-1: a write goes to FIN; a read goes to RTAIL.
- Read return:
  - Memory registers data on the posedge ending beat k.
  - rdata_valid=1 and rdata=mem_rdata in the cycle after beat k, i.e. BEAT cycles k=1..N-1 plus RTAIL.
  - rdata_last=1 coincident with the beat N-1 data (the RTAIL cycle).
- RTAIL: one cycle, then FIN.
- FIN: done=1, mem_wren=0, go to IDLE. req_ready is 0 in FIN and rises the following cycle.
- Latency, request accepted at cycle T:
  - Read: beats T+1..T+N; rdata T+2..T+N+1; done T+N+2; req_ready T+N+3.
  - Write: beats T+1..T+N; done T+N+1; req_ready T+N+2.
- req_valid and req_* inputs are ignored outside IDLE.
- Beat counter is 4 bits and never wraps: N ≤ 16, terminal at N-1.
- mem_busy is never used to advance state.

Optional Feature:
- Macro: MEM_BURST_MASTER_ADDR_CHECK_EN.
- Enabled:
  - In IDLE, a handshake is rejected if addr < START_ADDRESS or (addr - START_ADDRESS) + 4N > MEM_SIZE.
  - A rejected request produces an err pulse the cycle after the handshake. There is no memory access, no done pulse and no wdata_pop, and the state stays IDLE.
- Disabled: err tied 0; all requests proceed.

Test Plan:
- Reset asserted mid 16-word read (k=5) -> mem_enable and rdata_valid fall immediately; after release req_ready=1 and no done pulse.
- Single-word write, addr 32'h80020000, wdata 32'hDEADBEEF -> one cycle with mem_enable=1, mem_wren=1, mem_wdata=DEADBEEF, wdata_pop=1; done 2 cycles after handshake; follow-up 1-word read returns DEADBEEF with rdata_last=1.
- 4-word write of 1,2,3,4 at 32'h80020010, then 4-word read -> 4 pops; mem_addr constant 80020010 for all beats; read returns 1,2,3,4 on consecutive cycles, rdata_last on the 4th; done at T+6.
- 16-word read with req_valid held high throughout -> exactly 16 rdata_valid cycles; second request accepted only after req_ready returns at T+19.
- With MEM_BURST_MASTER_ADDR_CHECK_EN: 4-word request at 32'h80010000, and 4-word request at START_ADDRESS+MEM_SIZE-8 -> err pulse each, mem_enable never asserted; the same requests with the macro off proceed normally.
